ariane_wb_buffer: RTL
=====================

// Module: ariane_wb_buffer
// PURPOSE
//  Writeback buffer feeding the integer register file write ports.
//  Collects results from NR_IN_PORTS functional-unit writeback ports through valid/ready handshakes.
//  Queues them in a circular buffer of DEPTH entries.
//  Drains up to NR_COMMIT_PORTS entries per cycle onto waddr/wdata/we, in age order.
//  Decouples FU completion bursts from the fixed number of regfile write ports.
// PARAMETERS
//  DATA_WIDTH       64  width of one register value
//  NR_IN_PORTS      2   FU writeback input ports
//  NR_COMMIT_PORTS  2   regfile write ports driven per cycle
//  DEPTH            8   buffer entries; power of two, >= NR_IN_PORTS and >= NR_COMMIT_PORTS
//  DROP_X0          1   1: writes to address 0 are handshaken but never stored
// PORTS
//  clk_i        in   1                           clock, rising edge
//  rst_i        in   1                           reset, asynchronous, active-high
//  flush_i      in   1                           discard all buffered and incoming results
//  in_valid_i   in   NR_IN_PORTS                 per-port result valid
//  in_addr_i    in   NR_IN_PORTS*5               per-port destination register
//  in_data_i    in   NR_IN_PORTS*DATA_WIDTH      per-port result data
//  in_ready_o   out  1                           buffer can accept all ports this cycle
//  waddr_o      out  NR_COMMIT_PORTS*5           regfile write address per port
//  wdata_o      out  NR_COMMIT_PORTS*DATA_WIDTH  regfile write data per port
//  we_o         out  NR_COMMIT_PORTS             regfile write enable per port
//  count_o      out  $clog2(DEPTH)+1             occupied entries
// BEHAVIOUR
//  Reset (async, rst_i=1)
//   - rd_ptr, wr_ptr and count go to 0.
//   - Storage contents are don't-care.
//   - Outputs: we_o=0, waddr_o=0, wdata_o=0, count_o=0, in_ready_o=1.
//   - Reset asserted mid-operation drops every entry immediately; nothing is written afterwards.
//  Accept
//   - in_ready_o = (DEPTH-count) >= NR_IN_PORTS; it depends on registered count only and never on the current drain.
//   - Port k is accepted when in_valid_i[k] && in_ready_o && !flush_i.
//   - Accepted ports are stored at wr_ptr in ascending port order: port 0 is older than port 1 in the same cycle.
//   - Gaps from non-valid ports are compacted.
//   - With DROP_X0=1, a port carrying in_addr_i==0 is accepted but not stored and consumes no slot.
//  Drain
//   - n = min(count, NR_COMMIT_PORTS), computed from registered count.
//   - For j<n: we_o[j]=1, waddr_o[j]/wdata_o[j] = entry (rd_ptr+j) mod DEPTH, so port 0 carries the oldest entry.
//   - For j>=n: we_o[j]=0 and waddr_o/wdata_o for that port are 0.
//   - Outputs are combinational from storage. The regfile always accepts, so drained entries leave at the next edge: rd_ptr += n.
//   - Same-address entries drained together: the younger entry sits on a higher port index. The regfile applies higher ports last, so the younger value wins.
//  Latency
//   - An entry accepted in cycle t appears on we_o no earlier than cycle t+1.
//   - It appears exactly at t+1 when no more than NR_COMMIT_PORTS-1 older entries remain ahead of it.
//   - No combinational path exists from in_* to we_o/waddr_o/wdata_o.
//  Pointers
//   - Both pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - count_next = count - n + stored; enqueue and drain in the same cycle are legal.
//   - The ready rule keeps count <= DEPTH.
//  Flush
//   - flush_i=1 forces we_o=0 in that cycle and accepts nothing.
//   - At the next edge rd_ptr=wr_ptr=count=0. in_ready_o is 1 in the following cycle.
//  Assertions: count<=DEPTH; count_o==0 implies we_o==0; we_o is thermometer-coded (we_o[j] implies we_o[j-1]).
// TESTING
//  T1 Reset
//   - Stimulus: assert rst_i with 3 entries buffered.
//   - Response: same cycle we_o=0, count_o=0, in_ready_o=1; after release, no stale writes.
//  T2 Single result
//   - Stimulus: port0 addr=5 data=0xA5 at cycle t.
//   - Response: cycle t+1 shows we_o=2'b01, waddr_o[0]=5, wdata_o[0]=0xA5; count_o=0 at t+2.
//  T3 Dual issue ordering
//   - Stimulus: port0 (7,0x1) and port1 (7,0x2) in the same cycle.
//   - Response: next cycle we_o=2'b11, port0=0x1, port1=0x2; regfile x7 ends at 0x2.
//  T4 Backpressure
//   - Stimulus: block the drain for a synthetic check by filling faster than it empties (dual-valid every cycle while count rises).
//   - Response: in_ready_o falls at count=7; no entry is lost; all entries drain in order.
//  T5 x0 drop
//   - Stimulus: port0 addr=0 and port1 addr=3 both valid.
//   - Response: only addr 3 is stored; count_o +1; we_o=2'b01 next cycle.
//  T6 Flush and wrap
//   - Stimulus: run wr_ptr past DEPTH with a 20-result stream, then flush_i with 4 entries buffered.
//   - Response: data order is preserved across the wrap; flush cycle shows we_o=0; next cycle count_o=0 and in_ready_o=1.

Source files
------------

// File: rtl/ariane_wb_buffer_if.sv
// Writeback buffer bus: FU-side valid/ready result handshake plus the
// regfile write-port bundle driven by the buffer.
interface ariane_wb_buffer_if #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned NR_IN_PORTS     = 2,
  parameter int unsigned NR_COMMIT_PORTS = 2
);
  logic [NR_IN_PORTS-1:0]                in_valid_i;
  logic [NR_IN_PORTS*5-1:0]              in_addr_i;
  logic [NR_IN_PORTS*DATA_WIDTH-1:0]     in_data_i;
  logic                                  in_ready_o;
  logic [NR_COMMIT_PORTS*5-1:0]          waddr_o;
  logic [NR_COMMIT_PORTS*DATA_WIDTH-1:0] wdata_o;
  logic [NR_COMMIT_PORTS-1:0]            we_o;

  // Producer side: functional units push results and observe the regfile writes
  modport master (
    output in_valid_i, in_addr_i, in_data_i,
    input  in_ready_o, waddr_o, wdata_o, we_o
  );

  // Buffer side
  modport slave (
    input  in_valid_i, in_addr_i, in_data_i,
    output in_ready_o, waddr_o, wdata_o, we_o
  );
endinterface

// File: rtl/ariane_wb_buffer.sv
// Writeback buffer: collects FU results into a circular queue and drains up
// to NR_COMMIT_PORTS of them per cycle onto the regfile write ports, oldest
// entry on the lowest port.
module ariane_wb_buffer #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned NR_IN_PORTS     = 2,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned DROP_X0         = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  ariane_wb_buffer_if.slave        wb,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]            r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;

  logic                  w_ready;
  logic [NR_IN_PORTS-1:0] w_store;
  logic [PW-1:0]         w_slot [NR_IN_PORTS];
  logic [CW-1:0]         w_stored;
  logic [CW-1:0]         w_n;

  // Ready looks only at the registered fill level so a full-width burst always fits
  assign w_ready       = (r_count <= CW'(DEPTH - NR_IN_PORTS));
  assign wb.in_ready_o = w_ready;
  assign count_o       = r_count;

  // Accept: compact the stored ports into consecutive slots, port 0 oldest
  always_comb begin
    logic [CW-1:0] w_acc;
    w_acc = '0;
    for (int unsigned k = 0; k < NR_IN_PORTS; k++) begin
      w_store[k] = wb.in_valid_i[k] && w_ready && !flush_i &&
                   !((DROP_X0 != 0) && (wb.in_addr_i[k*5 +: 5] == 5'd0));
      w_slot[k]  = r_wr_ptr + PW'(w_acc);
      if (w_store[k]) begin
        w_acc = w_acc + CW'(1);
      end
    end
    w_stored = w_acc;
  end

  // Drain: present the n oldest entries; unused ports are zeroed
  always_comb begin
    logic [PW-1:0] w_idx;
    w_idx      = '0;
    w_n        = (r_count < CW'(NR_COMMIT_PORTS)) ? r_count : CW'(NR_COMMIT_PORTS);
    wb.we_o    = '0;
    wb.waddr_o = '0;
    wb.wdata_o = '0;
    for (int unsigned j = 0; j < NR_COMMIT_PORTS; j++) begin
      if (!flush_i && (CW'(j) < w_n)) begin
        w_idx                               = r_rd_ptr + PW'(j);
        wb.we_o[j]                          = 1'b1;
        wb.waddr_o[j*5 +: 5]                = r_addr[w_idx];
        wb.wdata_o[j*DATA_WIDTH +: DATA_WIDTH] = r_data[w_idx];
      end
    end
  end

  // Storage array; contents are only meaningful between rd_ptr and wr_ptr
  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NR_IN_PORTS; k++) begin
      if (w_store[k]) begin
        r_addr[w_slot[k]] <= wb.in_addr_i[k*5 +: 5];
        r_data[w_slot[k]] <= wb.in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue at the edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PW'(w_n);
      r_wr_ptr <= r_wr_ptr + PW'(w_stored);
      r_count  <= r_count - w_n + w_stored;
    end
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    r_count <= CW'(DEPTH));
  a_empty_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_count == '0) |-> (wb.we_o == '0));
  for (genvar j = 1; j < NR_COMMIT_PORTS; j++) begin : g_therm
    a_we_therm: assert property (@(posedge clk_i) disable iff (rst_i)
      wb.we_o[j] |-> wb.we_o[j-1]);
  end

endmodule
